// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: set-2 scan-code parser (E0/F0 prefixes) tracking held/press/release for arrows and space; optional sequence timeout via PS2_TIMEOUT_EN
module ps2_key_tracker #(
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int CNT_W = 18
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic [7:0] ps2_data,
  input  logic       ps2_data_en,
  input  logic       clear_keys,
  output logic [4:0] key_held,
  output logic [4:0] key_press,
  output logic [4:0] key_release,
  output logic       code_valid,
  output logic [7:0] code,
  output logic       code_ext,
  output logic       code_brk,
  output logic       seq_err,
  output logic [1:0] fsm_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_t;
  state_t st, nxt;
  logic is_e0, is_f0, emit, perr, tmo;
  logic [4:0] hit, held_n;
  assign is_e0 = ps2_data == 8'hE0;
  assign is_f0 = ps2_data == 8'hF0;
  assign emit = ps2_data_en & ~is_e0 & ~is_f0;
  assign perr = ps2_data_en & ((is_e0 & st[1]) | (is_f0 & (st == EXT_BRK)));
  assign hit = {~st[0] & (ps2_data == 8'h29), st[0] & (ps2_data == 8'h72), st[0] & (ps2_data == 8'h75),
                st[0] & (ps2_data == 8'h6B), st[0] & (ps2_data == 8'h74)};
  assign held_n = clear_keys ? '0 : !emit ? key_held : st[1] ? key_held & ~hit : key_held | hit;
  assign fsm_state = st;
  always_comb
    nxt = tmo ? IDLE : !ps2_data_en ? st :
          is_e0 ? (st == EXT_BRK ? IDLE : EXT) :
          is_f0 ? (st == EXT_BRK ? IDLE : state_t'({1'b1, st[0]})) : IDLE;
`ifdef PS2_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  assign tmo = (st != IDLE) && !ps2_data_en && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) cnt <= '0;
    else cnt <= (ps2_data_en || st == IDLE || tmo) ? '0 : cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  always_ff @(posedge CLOCK_50 or negedge resetn)
    if (!resetn) begin
      st          <= IDLE;
      key_held    <= '0;
      key_press   <= '0;
      key_release <= '0;
      code_valid  <= 1'b0;
      code        <= '0;
      code_ext    <= 1'b0;
      code_brk    <= 1'b0;
      seq_err     <= 1'b0;
    end else begin
      st          <= nxt;
      key_held    <= held_n;
      key_press   <= held_n & ~key_held;
      key_release <= clear_keys ? '0 : key_held & ~held_n;
      code_valid  <= emit;
      seq_err     <= perr | tmo;
      if (emit) {code, code_ext, code_brk} <= {ps2_data, st[0], st[1]};
    end
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: table vectors, hand sequences and randomized traffic against a scan-code reference model
module tb_ps2_key_tracker;
  localparam int TO = 100;
  logic CLOCK_50 = 1'b0, resetn, ps2_data_en, clear_keys, code_valid, code_ext, code_brk, seq_err;
  logic [7:0] ps2_data, code;
  logic [4:0] key_held, key_press, key_release;
  logic [1:0] fsm_state;
  int n_checks = 0, n_errors = 0;

  ps2_key_tracker #(.TIMEOUT_CYCLES(TO), .CNT_W(18)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .ps2_data(ps2_data), .ps2_data_en(ps2_data_en),
    .clear_keys(clear_keys), .key_held(key_held), .key_press(key_press), .key_release(key_release),
    .code_valid(code_valid), .code(code), .code_ext(code_ext), .code_brk(code_brk),
    .seq_err(seq_err), .fsm_state(fsm_state));

  always #5 CLOCK_50 = ~CLOCK_50;

  // reference model: pending prefix flags plus expected registered outputs
  logic m_ext, m_brk;
  int m_idle;
  logic [4:0] e_held, e_press, e_rel;
  logic e_valid, e_ext, e_brk, e_err;
  logic [7:0] e_code;
  logic [1:0] e_state;

  function automatic int key_of(input logic [7:0] d, input logic ext);
    if (!ext) return d == 8'h29 ? 4 : -1;
    case (d)
      8'h74: return 0;
      8'h6B: return 1;
      8'h75: return 2;
      8'h72: return 3;
      default: return -1;
    endcase
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_idle = 0;
    e_held = 0; e_press = 0; e_rel = 0; e_valid = 0; e_ext = 0; e_brk = 0; e_err = 0; e_code = 0; e_state = 0;
  endtask

  task automatic model(input logic [7:0] d, input logic en, input logic clr);
    logic [4:0] nh;
    int k;
    nh = e_held; e_valid = 0; e_err = 0;
    if (en) begin
      m_idle = 0;
      if (d == 8'hE0) begin
        if (m_brk && m_ext) begin e_err = 1; m_brk = 0; m_ext = 0; end
        else if (m_brk) begin e_err = 1; m_brk = 0; m_ext = 1; end
        else m_ext = 1;
      end else if (d == 8'hF0) begin
        if (m_brk && m_ext) begin e_err = 1; m_brk = 0; m_ext = 0; end
        else m_brk = 1;
      end else begin
        e_valid = 1; e_code = d; e_ext = m_ext; e_brk = m_brk;
        k = key_of(d, m_ext);
        if (k >= 0) nh[k] = !m_brk;
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
`ifdef PS2_TIMEOUT_EN
      m_idle++;
      if (m_idle == TO) begin e_err = 1; m_ext = 0; m_brk = 0; m_idle = 0; end
`endif
    end
    e_press = clr ? 5'd0 : nh & ~e_held;
    e_rel = clr ? 5'd0 : e_held & ~nh;
    e_held = clr ? 5'd0 : nh;
    e_state = {m_brk, m_ext};
  endtask

  task automatic step(input logic [7:0] d, input logic en, input logic clr);
    ps2_data = d; ps2_data_en = en; clear_keys = clr;
    model(d, en, clr);
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got held/press/rel/valid/code/ext/brk/err/st=%h required %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] dut_vec();
    return {5'd0, key_held, key_press, key_release, code_valid, code, code_ext, code_brk, seq_err, fsm_state};
  endfunction

  function automatic logic [39:0] model_vec();
    return {5'd0, e_held, e_press, e_rel, e_valid, e_code, e_ext, e_brk, e_err, e_state};
  endfunction

  typedef struct {
    logic [7:0] d; logic en, clr;
    logic [4:0] held, press, rel;
    logic valid; logic [7:0] code; logic ext, brk, err; logic [1:0] st;
  } vec_t;
  vec_t tv[22];

  initial begin
    int first;
    logic [7:0] pool[8];
    pool[0] = 8'hE0; pool[1] = 8'hF0; pool[2] = 8'h74; pool[3] = 8'h6B;
    pool[4] = 8'h75; pool[5] = 8'h72; pool[6] = 8'h29; pool[7] = 8'hE1;
    tv[0]  = '{8'hE0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 8'h00, 0, 0, 0, 2'd1};
    tv[1]  = '{8'h75, 1, 0, 5'h04, 5'h04, 5'h00, 1, 8'h75, 1, 0, 0, 2'd0};
    tv[2]  = '{8'hE0, 1, 0, 5'h04, 5'h00, 5'h00, 0, 8'h75, 1, 0, 0, 2'd1};
    tv[3]  = '{8'hF0, 1, 0, 5'h04, 5'h00, 5'h00, 0, 8'h75, 1, 0, 0, 2'd3};
    tv[4]  = '{8'h75, 1, 0, 5'h00, 5'h00, 5'h04, 1, 8'h75, 1, 1, 0, 2'd0};
    tv[5]  = '{8'h75, 1, 0, 5'h00, 5'h00, 5'h00, 1, 8'h75, 0, 0, 0, 2'd0};
    tv[6]  = '{8'hF0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 8'h75, 0, 0, 0, 2'd2};
    tv[7]  = '{8'h75, 1, 0, 5'h00, 5'h00, 5'h00, 1, 8'h75, 0, 1, 0, 2'd0};
    tv[8]  = '{8'h29, 1, 0, 5'h10, 5'h10, 5'h00, 1, 8'h29, 0, 0, 0, 2'd0};
    tv[9]  = '{8'h29, 1, 0, 5'h10, 5'h00, 5'h00, 1, 8'h29, 0, 0, 0, 2'd0};
    tv[10] = '{8'h29, 1, 0, 5'h10, 5'h00, 5'h00, 1, 8'h29, 0, 0, 0, 2'd0};
    tv[11] = '{8'h00, 0, 1, 5'h00, 5'h00, 5'h00, 0, 8'h29, 0, 0, 0, 2'd0};
    tv[12] = '{8'hE0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 8'h29, 0, 0, 0, 2'd1};
    tv[13] = '{8'hF0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 8'h29, 0, 0, 0, 2'd3};
    tv[14] = '{8'hE0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 8'h29, 0, 0, 1, 2'd0};
    tv[15] = '{8'hF0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 8'h29, 0, 0, 0, 2'd2};
    tv[16] = '{8'hE0, 1, 0, 5'h00, 5'h00, 5'h00, 0, 8'h29, 0, 0, 1, 2'd1};
    tv[17] = '{8'h74, 1, 0, 5'h01, 5'h01, 5'h00, 1, 8'h74, 1, 0, 0, 2'd0};
    tv[18] = '{8'h00, 0, 0, 5'h01, 5'h00, 5'h00, 0, 8'h74, 1, 0, 0, 2'd0};
    tv[19] = '{8'hE0, 1, 0, 5'h01, 5'h00, 5'h00, 0, 8'h74, 1, 0, 0, 2'd1};
    tv[20] = '{8'h6B, 1, 1, 5'h00, 5'h00, 5'h00, 1, 8'h6B, 1, 0, 0, 2'd0};
    tv[21] = '{8'hE1, 1, 0, 5'h00, 5'h00, 5'h00, 1, 8'hE1, 0, 0, 0, 2'd0};

    resetn = 0; ps2_data = 0; ps2_data_en = 0; clear_keys = 0;
    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("reset_state", dut_vec(), 40'd0);
    @(negedge CLOCK_50) resetn = 1;

    for (int i = 0; i < 22; i++) begin
      step(tv[i].d, tv[i].en, tv[i].clr);
      check($sformatf("vec%0d", i), dut_vec(),
            {5'd0, tv[i].held, tv[i].press, tv[i].rel, tv[i].valid, tv[i].code, tv[i].ext, tv[i].brk, tv[i].err, tv[i].st});
      check($sformatf("vec%0d_model", i), dut_vec(), model_vec());
    end

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 9) < 8) ? pool[$urandom_range(0, 7)] : 8'($urandom);
      step(d, $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      check("random", dut_vec(), model_vec());
    end

`ifdef PS2_TIMEOUT_EN
    step(8'h00, 0, 1);
    step(8'hE0, 1, 0);
    check("to_arm", dut_vec(), model_vec());
    first = -1;
    for (int i = 1; i <= 2 * TO; i++) begin
      step(8'h00, 0, 0);
      check("to_wait", dut_vec(), model_vec());
      if (seq_err && first < 0) first = i;
      if (first >= 0) break;
    end
    check("to_latency", 40'(first), 40'(TO));
    check("to_state", 40'(fsm_state), 40'd0);
    step(8'h74, 1, 0);
    check("to_after", {30'd0, key_held, code_ext, code_valid, seq_err, fsm_state}, {30'd0, 5'd0, 1'b0, 1'b1, 1'b0, 2'd0});
`else
    first = 0;
`endif

    step(8'hE0, 1, 0);
    step(8'h29, 1, 0);
    step(8'hE0, 1, 0);
    step(8'hF0, 1, 0);
    check("pre_reset", dut_vec(), model_vec());
    #2 resetn = 0;
    #1;
    check("async_reset", dut_vec(), 40'd0);
    model_reset();
    @(negedge CLOCK_50) resetn = 1;
    step(8'h74, 1, 0);
    check("post_reset_74", dut_vec(), {5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 8'h74, 1'b0, 1'b0, 1'b0, 2'd0});
    check("post_reset_model", dut_vec(), model_vec());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
